// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block types and packer state encoding
package aes_pkg;

  localparam int BLOCK_WIDTH = 128;
  localparam int BLOCK_BYTES = BLOCK_WIDTH / 8;

  typedef logic [BLOCK_WIDTH-1:0] block_t;
  typedef logic [BLOCK_BYTES-1:0] keep_t;

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } packer_state_t;

endpackage

// File: rtl/keep_check.sv
// rtl/keep_check.sv - flags byte-keep patterns that break the MSB-first contiguous rule
module keep_check #(
  parameter int KW = 4
) (
  input  logic [KW-1:0] i_tkeep,
  input  logic          i_tlast,
  output logic          o_err
);

  logic w_noncontig;
  logic w_partial;

  // A valid byte below an invalid one means a hole in the MSB-first run.
  always_comb begin
    w_noncontig = 1'b0;
    for (int j = 0; j < KW - 1; j++) begin
      if (i_tkeep[j] && !i_tkeep[j+1]) begin
        w_noncontig = 1'b1;
      end
    end
  end

  assign w_partial = !i_tlast && (i_tkeep != {KW{1'b1}});
  assign o_err     = w_noncontig | w_partial;

endmodule

// File: rtl/axis_block_packer.sv
// rtl/axis_block_packer.sv - packs narrow byte-stream words into AES-width blocks
module axis_block_packer
  import aes_pkg::*;
#(
  parameter int S_TDATA_WIDTH = 32,
  parameter int BLOCK_WIDTH   = aes_pkg::BLOCK_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [S_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [BLOCK_WIDTH-1:0]     m_axis_tdata,
  output logic [BLOCK_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       err
);

  localparam int WORDS = BLOCK_WIDTH / S_TDATA_WIDTH;
  localparam int KW    = S_TDATA_WIDTH / 8;
  localparam int BB    = BLOCK_WIDTH / 8;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  packer_state_t r_state, w_next_state;

  logic [IDX_W-1:0]         r_idx, w_idx_nxt, w_wr_idx;
  logic [BLOCK_WIDTH-1:0]   r_block, w_block_nxt;
  logic [BB-1:0]            r_keep, w_keep_nxt;
  logic                     r_last, w_last_nxt;
  logic                     r_err;
  logic [S_TDATA_WIDTH-1:0] w_word_masked;
  logic                     w_s_hs, w_m_hs, w_keep_err;

  keep_check #(
    .KW(KW)
  ) u_keep_check (
    .i_tkeep(s_axis_tkeep),
    .i_tlast(s_axis_tlast),
    .o_err  (w_keep_err)
  );

  assign w_s_hs = s_axis_tvalid & s_axis_tready;
  assign w_m_hs = m_axis_tvalid & m_axis_tready;

  always_comb begin
    w_word_masked = '0;
    for (int j = 0; j < KW; j++) begin
      w_word_masked[8*j +: 8] = s_axis_tkeep[j] ? s_axis_tdata[8*j +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // In OUT the input side only moves together with the output side, so a new
  // packet's first word can land in the same cycle the finished block leaves.
  always_comb begin
    w_next_state  = r_state;
    m_axis_tvalid = 1'b0;
    s_axis_tready = 1'b0;
    case (r_state)
      FILL: begin
        s_axis_tready = rst_n;
        if (w_s_hs && ((r_idx == IDX_W'(WORDS - 1)) || s_axis_tlast)) begin
          w_next_state = OUT;
        end
      end
      OUT: begin
        m_axis_tvalid = 1'b1;
        s_axis_tready = rst_n & m_axis_tready;
        if (w_m_hs) begin
          w_next_state = (w_s_hs && (s_axis_tlast || (WORDS == 1))) ? OUT : FILL;
        end
      end
      default: w_next_state = FILL;
    endcase
  end

  always_comb begin
    w_block_nxt = r_block;
    w_keep_nxt  = r_keep;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_wr_idx    = r_idx;
    if (w_m_hs) begin
      w_block_nxt = '0;
      w_keep_nxt  = '0;
      w_idx_nxt   = '0;
      w_last_nxt  = 1'b0;
      w_wr_idx    = '0;
    end
    if (w_s_hs) begin
      for (int i = 0; i < WORDS; i++) begin
        if (w_wr_idx == IDX_W'(i)) begin
          w_block_nxt[BLOCK_WIDTH-1-i*S_TDATA_WIDTH -: S_TDATA_WIDTH] = w_word_masked;
          w_keep_nxt[BB-1-i*KW -: KW] = s_axis_tkeep;
        end
      end
      w_idx_nxt  = w_wr_idx + IDX_W'(1);
      w_last_nxt = s_axis_tlast;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_block <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_block <= w_block_nxt;
      r_keep  <= w_keep_nxt;
      r_last  <= w_last_nxt;
      r_err   <= r_err | (w_s_hs & w_keep_err);
    end
  end

  assign m_axis_tdata = r_block;
  assign m_axis_tkeep = r_keep;
  assign m_axis_tlast = r_last;
  assign err          = r_err;

endmodule

// File: tb/tb_axis_block_packer.sv
// tb/tb_axis_block_packer.sv - directed vector bench for axis_block_packer
module tb_axis_block_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  s_axis_tdata;
  logic [3:0]   s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axis_block_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .err          (err)
  );

  typedef struct {
    logic [31:0]  d;
    logic [3:0]   k;
    logic         l;
    logic         exp_out;
    logic [127:0] exp_data;
    logic [15:0]  exp_keep;
    logic         exp_last;
    logic         exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got tready=0 expected tready=1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic take_block();
    @(negedge clk);
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    chk("tvalid_after_take", m_axis_tvalid, 1'b0);
  endtask

  task automatic chk_block(input string name, input logic [127:0] d, input logic [15:0] k,
                           input logic l, input logic e);
    chk({name, "_tvalid"}, m_axis_tvalid, 1'b1);
    chk({name, "_tdata"}, m_axis_tdata, d);
    chk({name, "_tkeep"}, m_axis_tkeep, k);
    chk({name, "_tlast"}, m_axis_tlast, l);
    chk({name, "_err"}, err, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    // 16-byte packet, 20-byte packet, 7-byte packet, keep-zero end marker
    vecs.push_back('{32'h00010203, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0, 1'b0});
    vecs.push_back('{32'h04050607, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0, 1'b0});
    vecs.push_back('{32'h08090a0b, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0, 1'b0});
    vecs.push_back('{32'h0c0d0e0f, 4'hF, 1'b1, 1'b1,
                     128'h000102030405060708090a0b0c0d0e0f, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h00010203, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0, 1'b0});
    vecs.push_back('{32'h04050607, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0, 1'b0});
    vecs.push_back('{32'h08090a0b, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0, 1'b0});
    vecs.push_back('{32'h0c0d0e0f, 4'hF, 1'b0, 1'b1,
                     128'h000102030405060708090a0b0c0d0e0f, 16'hFFFF, 1'b0, 1'b0});
    vecs.push_back('{32'h10111213, 4'hF, 1'b1, 1'b1,
                     128'h10111213000000000000000000000000, 16'hF000, 1'b1, 1'b0});
    vecs.push_back('{32'h00010203, 4'hF, 1'b0, 1'b0, 128'h0, 16'h0, 1'b0, 1'b0});
    vecs.push_back('{32'haabbcc77, 4'hE, 1'b1, 1'b1,
                     128'h00010203aabbcc000000000000000000, 16'hFE00, 1'b1, 1'b0});
    vecs.push_back('{32'hdeadbeef, 4'h0, 1'b1, 1'b1, 128'h0, 16'h0000, 1'b1, 1'b0});

    repeat (2) @(negedge clk);
    chk("rst_s_tready", s_axis_tready, 1'b0);
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_m_tlast", m_axis_tlast, 1'b0);
    chk("rst_m_tkeep", m_axis_tkeep, 16'h0);
    chk("rst_m_tdata", m_axis_tdata, 128'h0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      send_word(vecs[i].d, vecs[i].k, vecs[i].l);
      chk($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].exp_out);
      chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      if (vecs[i].exp_out) begin
        chk($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].exp_data);
        chk($sformatf("vec%0d_tkeep", i), m_axis_tkeep, vecs[i].exp_keep);
        chk($sformatf("vec%0d_tlast", i), m_axis_tlast, vecs[i].exp_last);
        take_block();
      end
    end

    // Backpressure: block held 10 cycles, then released together with a new first word
    send_word(32'h10111213, 4'hF, 1'b0);
    send_word(32'h14151617, 4'hF, 1'b0);
    send_word(32'h18191a1b, 4'hF, 1'b0);
    send_word(32'h1c1d1e1f, 4'hF, 1'b1);
    @(negedge clk);
    s_axis_tdata  = 32'h20212223;
    s_axis_tkeep  = 4'hF;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_s_tready", s_axis_tready, 1'b0);
      chk("bp_tvalid", m_axis_tvalid, 1'b1);
      chk("bp_tdata", m_axis_tdata, 128'h101112131415161718191a1b1c1d1e1f);
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    #1;
    chk("bp_release_s_tready", s_axis_tready, 1'b1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    chk("bp_after_release_tvalid", m_axis_tvalid, 1'b0);
    send_word(32'h24252627, 4'hF, 1'b0);
    send_word(32'h28292a2b, 4'hF, 1'b0);
    send_word(32'h2c2d2e2f, 4'hF, 1'b1);
    chk_block("bp_next", 128'h202122232425262728292a2b2c2d2e2f, 16'hFFFF, 1'b1, 1'b0);
    take_block();

    // Non-contiguous keep on a non-last beat sets the sticky error
    send_word(32'h11223344, 4'hA, 1'b0);
    chk("err_set", err, 1'b1);
    send_word(32'h55667788, 4'hF, 1'b0);
    send_word(32'h99aabbcc, 4'hF, 1'b0);
    send_word(32'hddeeff00, 4'hF, 1'b1);
    chk_block("err_pkt", 128'h1100330055667788_99aabbccddeeff00, 16'hAFFF, 1'b1, 1'b1);
    take_block();
    send_word(32'h01020304, 4'hF, 1'b1);
    chk_block("err_sticky", 128'h01020304000000000000000000000000, 16'hF000, 1'b1, 1'b1);
    take_block();

    // Reset mid-packet discards the partial block and clears the error
    send_word(32'h40414243, 4'hF, 1'b0);
    send_word(32'h44454647, 4'hF, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_s_tready", s_axis_tready, 1'b0);
    chk("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_tkeep", m_axis_tkeep, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_idle_tvalid", m_axis_tvalid, 1'b0);
    end
    send_word(32'h30313233, 4'hF, 1'b0);
    send_word(32'h34353637, 4'hF, 1'b0);
    send_word(32'h38393a3b, 4'hF, 1'b0);
    send_word(32'h3c3d3e3f, 4'hF, 1'b1);
    chk_block("postrst", 128'h303132333435363738393a3b3c3d3e3f, 16'hFFFF, 1'b1, 1'b0);
    take_block();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_block_packer.md
Name: axis_block_packer

Overview:
- Upstream stage of every AES core (ECB iterative/combinational/pipelined, CTR pipelined).
- Accepts the 32-bit AXI-Stream byte packets produced by the system or bench, packs them into 128-bit AES blocks, and presents one block per beat to the core's 128-bit AXI-Stream input.
- A final partial block is zero-padded and flagged via byte keep, so CTR can truncate and ECB can reject.

Parameters:
- S_TDATA_WIDTH, 32, input word width in bits; must divide BLOCK_WIDTH; multiple of 8.
- BLOCK_WIDTH, 128, output block width in bits (AES block).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  S_TDATA_WIDTH  input word; byte 0 of the word in bits [W-1:W-8].
- s_axis_tkeep  in  S_TDATA_WIDTH/8  byte valid; bit k = byte k (MSB-first order).
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last word of packet.
- m_axis_tdata  out  BLOCK_WIDTH  packed block; packet byte 0 in bits [127:120].
- m_axis_tkeep  out  BLOCK_WIDTH/8  valid bytes of block, MSB-first contiguous.
- m_axis_tvalid  out  1  block valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  block ends packet.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=FILL, word index=0, block register=0, m_axis_tkeep=0.
  - m_axis_tvalid=0, m_axis_tlast=0, err=0, s_axis_tready=0 while in reset.
- WORDS = BLOCK_WIDTH/S_TDATA_WIDTH (4).
- FILL state:
  - s_axis_tready=1.
  - On handshake, the word is written to slot idx (slot 0 = bits [127:96]) and its keep to keep slot idx. Bytes with tkeep=0 are forced to 0 in the block.
  - idx increments; transition to OUT when idx==WORDS-1 or tlast=1. m_axis_tlast := s_axis_tlast.
- OUT state:
  - m_axis_tvalid=1; data, keep and last are stable until the handshake.
  - s_axis_tready = m_axis_tready (combinational pass-through).
  - On m handshake without simultaneous s handshake: clear block and keep, idx=0, go to FILL.
  - On simultaneous m and s handshakes: the new word loads slot 0 of a cleared block, idx=1. Stay in OUT if that word had tlast (WORDS=1 case) or WORDS==1; otherwise go to FILL.
- Throughput: one block per WORDS cycles when both sides are always ready. Latency from last input word handshake to m_axis_tvalid is 1 cycle.
- Partial block (tlast before slot WORDS-1): unfilled slots are 0 and their keep is 0.
- Protocol errors (err is set and never cleared except by reset); data is still packed as received:
  - tkeep non-contiguous from the MSB.
  - tkeep != all-ones on a non-tlast beat.
- tkeep all-zero with tlast in slot 0: emits a block with keep=0 and tlast=1 (packet-end marker). Not an error.
- Backpressure: block held indefinitely while m_axis_tready=0; no input is accepted during that time.
- Reset mid-packet: partial block discarded; no output after rst_n deasserts until new input arrives.

Decomposition:
- Shared package aes_pkg holds:
  - BLOCK_WIDTH=128 and BLOCK_BYTES=16.
  - typedef block_t (logic [127:0]) and keep_t (logic [15:0]).
  - enum packer_state_t {FILL, OUT}.
- Sub-module keep_check: combinational; flags non-contiguous or partial-on-non-last tkeep. It is reused by the downstream unpacker.

Test Plan:
- Packet of 16 bytes 00..0F, all tkeep=F, tlast on 4th word -> one block 000102..0F, keep=FFFF, tlast=1, tvalid 1 cycle after 4th handshake.
- Packet of 20 bytes 00..13 (last word keep=F, tlast) -> block 1: 00..0F, keep FFFF, tlast 0; block 2: 10111213 followed by 24 zero hex digits, keep F000, tlast 1.
- Packet of 7 bytes, last word AABBCCxx with keep=E -> block 00010203AABBCC00 followed by zeros, keep FE00, tlast 1, err 0.
- m_axis_tready=0 for 10 cycles with block pending -> s_axis_tready=0 and block stable for all 10 cycles; on release, next packet's first word is accepted in the same cycle as the block handshake.
- tkeep=A on a non-last beat -> err=1 and stays 1; later clean packets still pack correctly with err remaining 1.
- Assert rst_n=0 after 2 words of a 4-word packet, then send a fresh 16-byte packet -> only the fresh block appears, with correct data and err=0.
